framebuffer_writer: RTL and testbench
=====================================

// Module: framebuffer_writer
// PURPOSE
//  Parametrised pixel-stream to framebuffer-BRAM write port. Takes a valid-qualified pixel
//  stream with start-of-frame and end-of-line strobes and tracks x/y position. Drives BRAM
//  write address/data/enable with no multiplier; row base advances by FRAME_WIDTH per line.
//  Sits between camera/stream decode and the frame BRAM write port; replaces the
//  free-running address-counter writer.
// PARAMETERS
//  FRAME_WIDTH   240  pixels per line (>=2)
//  FRAME_HEIGHT  320  lines per frame (>=2)
//  PIXEL_WIDTH   12   bits per pixel
//  ADDR_WIDTH    17   BRAM address bits; must satisfy 2**ADDR_WIDTH >= FRAME_WIDTH*FRAME_HEIGHT
// PORTS
//  clk           in   1            system clock, all logic on posedge
//  rst_n         in   1            async active-low reset
//  axiiv         in   1            pixel valid
//  axiid         in   PIXEL_WIDTH  pixel data
//  frame_start   in   1            strobe: qualifies first pixel of frame (with or without axiiv)
//  line_end      in   1            strobe: end of current line (with or without axiiv)
//  bram_we       out  1            BRAM write enable
//  bram_addr     out  ADDR_WIDTH   BRAM write address
//  bram_data_in  out  PIXEL_WIDTH  BRAM write data
//  x_count       out  16           current column
//  y_count       out  16           current line
//  frame_done    out  1            1-cycle pulse: last line of frame closed
//  err_overflow  out  1            sticky: pixel dropped (x>=FRAME_WIDTH or waiting for SOF)
//  err_short     out  1            sticky: frame_start arrived mid-frame
// BEHAVIOUR
//  - rst_n low (async): state=WAIT_SOF, bram_we=0, bram_addr=0, bram_data_in=0,
//    x_count=0, y_count=0, row_base=0, frame_done=0, err_* = 0. Mid-frame reset abandons the frame.
//  - States: WAIT_SOF (drop pixels) and ACTIVE. frame_start moves either state to ACTIVE with x=y=0.
//  - Write latency 1 cycle. Accepted pixel at (x,y): next cycle bram_we=1,
//    bram_addr=row_base+x, bram_data_in=axiid. bram_we=0 on any cycle with no accepted pixel.
//    Addr/data hold last value while bram_we=0.
//  - frame_start & axiiv same cycle: pixel written to addr 0; x becomes 1.
//  - ACTIVE, axiiv, x<FRAME_WIDTH: write, x<=x+1. x==FRAME_WIDTH: drop pixel, set err_overflow; x holds.
//  - line_end, y<FRAME_HEIGHT-1: after any same-cycle pixel is written at the current x,
//    x<=0, y<=y+1, row_base<=row_base+FRAME_WIDTH.
//  - line_end, y==FRAME_HEIGHT-1: same-cycle pixel written; frame_done pulses next cycle;
//    x=y=row_base=0; state=WAIT_SOF.
//  - WAIT_SOF: axiiv without frame_start sets err_overflow; line_end is ignored.
//  - frame_start in ACTIVE with (x!=0 or y!=0): set err_short; restart at 0.
//  - frame_start together with line_end: frame_start wins; line_end is ignored.
//  - Sticky errors clear only on reset.
//  - row_base+x never exceeds FRAME_WIDTH*FRAME_HEIGHT-1; widths are ADDR_WIDTH, unsigned.
// CONFIGURATION
//  DOUBLE_BUFFER_EN defined:
//    - Adds bram_addr bit ADDR_WIDTH (port width ADDR_WIDTH+1) as write bank select.
//    - Adds output disp_bank (1): bank the display reads, i.e. the last completed frame.
//    - Write bank resets to 0 and disp_bank resets to 1.
//    - On frame completion both toggle in the same cycle frame_done pulses.
//    - An aborted frame (err_short) does not toggle either bank.
//  DOUBLE_BUFFER_EN undefined: single bank; bram_addr is ADDR_WIDTH bits; no disp_bank port.
// TESTING
//  1 Reset then frame_start+axiiv, then 239 more pixels and line_end on the last one, W=240
//    -> addrs 0..239 written in order; y_count=1 next cycle.
//  2 Full 240x320 frame -> last write addr 76799; frame_done pulses exactly once; state WAIT_SOF.
//  3 Line of 242 pixels then line_end -> addrs 0..239 only; err_overflow=1; next line starts at 240.
//  4 Pixels before any frame_start -> bram_we stays 0; err_overflow=1.
//  5 frame_start at (x=10,y=5) -> err_short=1; next pixel written to addr 0.
//  6 With DOUBLE_BUFFER_EN, two full frames -> frame 1 written with bank bit 0, frame 2 with bank bit 1;
//    disp_bank reads 1, 0, 1 at reset, after frame 1 and after frame 2.
//    Drop rst_n mid-line -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/framebuffer_writer_if.sv
// Pixel-stream in / BRAM write port out bundle for framebuffer_writer.
// Optional feature macro: DOUBLE_BUFFER_EN (widens bram_addr by one bank-select bit).
// master: the writer (consumes the stream, drives the BRAM port).
// slave : the environment (drives the stream, observes the BRAM port).
interface framebuffer_writer_if #(
  parameter int PIXEL_WIDTH = 12,
  parameter int ADDR_WIDTH  = 17
);
`ifdef DOUBLE_BUFFER_EN
  localparam int BUS_ADDR_WIDTH = ADDR_WIDTH + 1;
`else
  localparam int BUS_ADDR_WIDTH = ADDR_WIDTH;
`endif

  logic                      axiiv;
  logic [PIXEL_WIDTH-1:0]    axiid;
  logic                      frame_start;
  logic                      line_end;
  logic                      bram_we;
  logic [BUS_ADDR_WIDTH-1:0] bram_addr;
  logic [PIXEL_WIDTH-1:0]    bram_data_in;

  modport master (
    input  axiiv, axiid, frame_start, line_end,
    output bram_we, bram_addr, bram_data_in
  );

  modport slave (
    output axiiv, axiid, frame_start, line_end,
    input  bram_we, bram_addr, bram_data_in
  );
endinterface

// File: rtl/framebuffer_writer.sv
// framebuffer_writer: turns a valid-qualified pixel stream with start-of-frame and
// end-of-line strobes into BRAM writes. Address = row_base + x, where row_base grows by
// FRAME_WIDTH per line, so no multiplier is needed.
// Optional feature macro: DOUBLE_BUFFER_EN adds a write-bank bit on top of bram_addr and a
// disp_bank output; both flip together when a frame completes.
module framebuffer_writer #(
  parameter int FRAME_WIDTH  = 240,
  parameter int FRAME_HEIGHT = 320,
  parameter int PIXEL_WIDTH  = 12,
  parameter int ADDR_WIDTH   = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  framebuffer_writer_if.master  bus,
  output logic [15:0]           x_count,
  output logic [15:0]           y_count,
  output logic                  frame_done,
  output logic                  err_overflow,
  output logic                  err_short
`ifdef DOUBLE_BUFFER_EN
  ,
  output logic                  disp_bank
`endif
);

`ifdef DOUBLE_BUFFER_EN
  localparam int BUS_ADDR_WIDTH = ADDR_WIDTH + 1;
`else
  localparam int BUS_ADDR_WIDTH = ADDR_WIDTH;
`endif

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t                    state_q, state_d;
  logic [15:0]               x_q, x_d;
  logic [15:0]               y_q, y_d;
  logic [ADDR_WIDTH-1:0]     row_base_q, row_base_d;
  logic                      we_q, we_d;
  logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PIXEL_WIDTH-1:0]    data_q, data_d;
  logic                      done_q, done_d;
  logic                      ovf_q, ovf_d;
  logic                      short_q, short_d;
  logic [BUS_ADDR_WIDTH-1:0] pix_addr;
  logic [BUS_ADDR_WIDTH-1:0] sof_addr;

`ifdef DOUBLE_BUFFER_EN
  logic bank_q, bank_d;

  // Bank bit sits above the pixel offset; the display always reads the other bank.
  assign pix_addr  = {bank_q, row_base_q + ADDR_WIDTH'(x_q)};
  assign sof_addr  = {bank_q, {ADDR_WIDTH{1'b0}}};
  assign disp_bank = ~bank_q;
`else
  assign pix_addr  = row_base_q + ADDR_WIDTH'(x_q);
  assign sof_addr  = '0;
`endif

  assign bus.bram_we      = we_q;
  assign bus.bram_addr    = addr_q;
  assign bus.bram_data_in = data_q;
  assign x_count          = x_q;
  assign y_count          = y_q;
  assign frame_done       = done_q;
  assign err_overflow     = ovf_q;
  assign err_short        = short_q;

  // Register all position, write-port and status state; reset abandons any open frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_SOF;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      short_q    <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
      bank_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      short_q    <= short_d;
`ifdef DOUBLE_BUFFER_EN
      bank_q     <= bank_d;
`endif
    end
  end

  // Next-state: frame_start dominates; in ACTIVE a same-cycle pixel is written at the
  // current x before line_end rewinds x, so the line_end assignments come last.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    short_d    = short_q;
`ifdef DOUBLE_BUFFER_EN
    bank_d     = bank_q;
`endif

    if (bus.frame_start) begin
      if (state_q == ACTIVE && (x_q != 16'd0 || y_q != 16'd0)) begin
        short_d = 1'b1;
      end
      state_d    = ACTIVE;
      x_d        = 16'd0;
      y_d        = 16'd0;
      row_base_d = '0;
      if (bus.axiiv) begin
        we_d   = 1'b1;
        addr_d = sof_addr;
        data_d = bus.axiid;
        x_d    = 16'd1;
      end
    end else if (state_q == ACTIVE) begin
      if (bus.axiiv) begin
        if (x_q < 16'(FRAME_WIDTH)) begin
          we_d   = 1'b1;
          addr_d = pix_addr;
          data_d = bus.axiid;
          x_d    = x_q + 16'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (bus.line_end) begin
        x_d = 16'd0;
        if (y_q < 16'(FRAME_HEIGHT - 1)) begin
          y_d        = y_q + 16'd1;
          row_base_d = row_base_q + ADDR_WIDTH'(FRAME_WIDTH);
        end else begin
          y_d        = 16'd0;
          row_base_d = '0;
          done_d     = 1'b1;
          state_d    = WAIT_SOF;
`ifdef DOUBLE_BUFFER_EN
          bank_d     = ~bank_q;
`endif
        end
      end
    end else begin
      if (bus.axiiv) begin
        ovf_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Self-checking bench for framebuffer_writer (W=240, H=8 so full frames stay short).
// Optional feature macro: DOUBLE_BUFFER_EN (bank bit and disp_bank checks).
module tb_framebuffer_writer;
  localparam int W  = 240;
  localparam int H  = 8;
  localparam int PW = 12;
  localparam int AW = 11;
`ifdef DOUBLE_BUFFER_EN
  localparam int BAW = AW + 1;
`else
  localparam int BAW = AW;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] x_count;
  logic [15:0] y_count;
  logic        frame_done;
  logic        err_overflow;
  logic        err_short;
`ifdef DOUBLE_BUFFER_EN
  logic        disp_bank;
  logic        exp_bank;
`endif

  typedef struct packed {
    logic [BAW-1:0] addr;
    logic [PW-1:0]  data;
  } exp_t;

  exp_t           exp_q[$];
  int             checks = 0;
  int             errors = 0;
  int             done_count = 0;
  logic [BAW-1:0] last_addr = '0;

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  framebuffer_writer_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

  framebuffer_writer #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .x_count(x_count),
    .y_count(y_count),
    .frame_done(frame_done),
    .err_overflow(err_overflow),
    .err_short(err_short)
`ifdef DOUBLE_BUFFER_EN
    ,
    .disp_bank(disp_bank)
`endif
  );

  // Expected full bus address for a pixel offset in the current write bank
  function automatic logic [BAW-1:0] exp_addr(input int a);
`ifdef DOUBLE_BUFFER_EN
    return {exp_bank, AW'(a)};
`else
    return BAW'(a);
`endif
  endfunction

  // Scoreboard: every write seen mid-cycle must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) done_count++;
      if (bus.bram_we) begin
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: got addr %0d data %0h, expected no write", bus.bram_addr, bus.bram_data_in);
        end else begin
          e = exp_q.pop_front();
          last_addr = bus.bram_addr;
          if (bus.bram_addr !== e.addr || bus.bram_data_in !== e.data) begin
            errors++;
            $display("[TB] FAIL write: got addr %0d data %0h, expected addr %0d data %0h", bus.bram_addr, bus.bram_data_in, e.addr, e.data);
          end
        end
      end
    end
  end

  // Global guard so the run always ends
  initial begin
    #3000000;
    $display("[TB] FAIL timeout: simulation still running, expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic cycle(input logic v, input logic [PW-1:0] d, input logic fs, input logic le);
    bus.axiiv       = v;
    bus.axiid       = d;
    bus.frame_start = fs;
    bus.line_end    = le;
    @(posedge clk);
    #1;
    bus.axiiv       = 1'b0;
    bus.frame_start = 1'b0;
    bus.line_end    = 1'b0;
  endtask

  task automatic send_pixel(input int a, input logic fs, input logic le);
    exp_t e;
    logic [PW-1:0] d;
    d = PW'($urandom);
    e.addr = exp_addr(a);
    e.data = d;
    exp_q.push_back(e);
    cycle(1'b1, d, fs, le);
  endtask

  task automatic drop_pixel(input logic le);
    cycle(1'b1, PW'($urandom), 1'b0, le);
  endtask

  task automatic send_line(input int y, input logic sof);
    for (int x = 0; x < W; x++) send_pixel(y * W + x, sof && (x == 0), x == W - 1);
  endtask

  task automatic send_frame();
    for (int y = 0; y < H; y++) send_line(y, y == 0);
`ifdef DOUBLE_BUFFER_EN
    exp_bank = ~exp_bank;
`endif
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.axiiv       = 1'b0;
    bus.axiid       = '0;
    bus.frame_start = 1'b0;
    bus.line_end    = 1'b0;
    exp_q.delete();
    done_count      = 0;
`ifdef DOUBLE_BUFFER_EN
    exp_bank        = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.bram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", bus.bram_we); end
    checks++; if (bus.bram_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", bus.bram_addr); end
    checks++; if (bus.bram_data_in !== '0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", bus.bram_data_in); end
    checks++; if (x_count !== 16'd0 || y_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_xy: got %0d,%0d expected 0,0", x_count, y_count); end
    checks++; if ({frame_done, err_overflow, err_short} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {frame_done, err_overflow, err_short}); end
`ifdef DOUBLE_BUFFER_EN
    checks++; if (disp_bank !== 1'b1) begin errors++; $display("[TB] FAIL reset_disp_bank: got %b expected 1", disp_bank); end
`endif
  endtask

  task automatic test_first_line();
    do_reset();
    send_line(0, 1'b1);
    checks++; if (y_count !== 16'd1) begin errors++; $display("[TB] FAIL line_y: got %0d expected 1", y_count); end
    checks++; if (x_count !== 16'd0) begin errors++; $display("[TB] FAIL line_x: got %0d expected 0", x_count); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL line_ovf: got %b expected 0", err_overflow); end
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL line_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_full_frame();
    do_reset();
    send_frame();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL frame_done_pulse: got %b expected 1", frame_done); end
    checks++; if (x_count !== 16'd0 || y_count !== 16'd0) begin errors++; $display("[TB] FAIL frame_xy: got %0d,%0d expected 0,0", x_count, y_count); end
    cycle(1'b0, '0, 1'b0, 1'b0);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL frame_done_width: got %b expected 0", frame_done); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL frame_ovf_before: got %b expected 0", err_overflow); end
    drop_pixel(1'b0);
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("[TB] FAIL frame_wait_sof: got ovf %b expected 1", err_overflow); end
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL frame_done_count: got %0d expected 1", done_count); end
`ifdef DOUBLE_BUFFER_EN
    checks++; if (last_addr !== {1'b0, AW'(W * H - 1)}) begin errors++; $display("[TB] FAIL frame_last_addr: got %0d expected %0d", last_addr, W * H - 1); end
`else
    checks++; if (last_addr !== AW'(W * H - 1)) begin errors++; $display("[TB] FAIL frame_last_addr: got %0d expected %0d", last_addr, W * H - 1); end
`endif
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL frame_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_pixel(0, 1'b1, 1'b0);
    for (int x = 1; x < W; x++) send_pixel(x, 1'b0, 1'b0);
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b expected 0", err_overflow); end
    drop_pixel(1'b0);
    drop_pixel(1'b1);
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", err_overflow); end
    checks++; if (x_count !== 16'd0 || y_count !== 16'd1) begin errors++; $display("[TB] FAIL ovf_xy: got %0d,%0d expected 0,1", x_count, y_count); end
    send_pixel(W, 1'b0, 1'b0);
    checks++; if (x_count !== 16'd1) begin errors++; $display("[TB] FAIL ovf_next_x: got %0d expected 1", x_count); end
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL ovf_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_no_sof();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drop_pixel(i == 2);
      checks++; if (bus.bram_we !== 1'b0) begin errors++; $display("[TB] FAIL nosof_we[%0d]: got %b expected 0", i, bus.bram_we); end
    end
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("[TB] FAIL nosof_ovf: got %b expected 1", err_overflow); end
    checks++; if (x_count !== 16'd0 || y_count !== 16'd0) begin errors++; $display("[TB] FAIL nosof_xy: got %0d,%0d expected 0,0", x_count, y_count); end
  endtask

  task automatic test_short();
    do_reset();
    for (int y = 0; y < 5; y++) send_line(y, y == 0);
    for (int x = 0; x < 10; x++) send_pixel(5 * W + x, 1'b0, 1'b0);
    checks++; if (x_count !== 16'd10 || y_count !== 16'd5) begin errors++; $display("[TB] FAIL short_pos: got %0d,%0d expected 10,5", x_count, y_count); end
    checks++; if (err_short !== 1'b0) begin errors++; $display("[TB] FAIL short_early: got %b expected 0", err_short); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (err_short !== 1'b1) begin errors++; $display("[TB] FAIL short_set: got %b expected 1", err_short); end
    checks++; if (x_count !== 16'd0 || y_count !== 16'd0) begin errors++; $display("[TB] FAIL short_restart: got %0d,%0d expected 0,0", x_count, y_count); end
    send_pixel(0, 1'b0, 1'b0);
    checks++; if (x_count !== 16'd1) begin errors++; $display("[TB] FAIL short_next_x: got %0d expected 1", x_count); end
`ifdef DOUBLE_BUFFER_EN
    checks++; if (disp_bank !== 1'b1) begin errors++; $display("[TB] FAIL short_bank: got %b expected 1", disp_bank); end
`endif
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL short_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_sof_line_end();
    do_reset();
    send_pixel(0, 1'b1, 1'b1);
    checks++; if (x_count !== 16'd1 || y_count !== 16'd0) begin errors++; $display("[TB] FAIL sof_le_xy: got %0d,%0d expected 1,0", x_count, y_count); end
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL sof_le_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame();
`ifdef DOUBLE_BUFFER_EN
    checks++; if (disp_bank !== 1'b0) begin errors++; $display("[TB] FAIL b2b_bank1: got %b expected 0", disp_bank); end
`endif
    send_frame();
    checks++; if (frame_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done2: got %b expected 1", frame_done); end
`ifdef DOUBLE_BUFFER_EN
    checks++; if (disp_bank !== 1'b1) begin errors++; $display("[TB] FAIL b2b_bank2: got %b expected 1", disp_bank); end
`endif
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    checks++; if (done_count != 2) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_pixel(0, 1'b1, 1'b0);
    send_pixel(1, 1'b0, 1'b0);
    checks++; if (bus.bram_we !== 1'b1 || x_count !== 16'd2) begin errors++; $display("[TB] FAIL arst_pre: got we %b x %0d expected we 1 x 2", bus.bram_we, x_count); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.bram_we !== 1'b0 || bus.bram_addr !== '0 || bus.bram_data_in !== '0) begin errors++; $display("[TB] FAIL arst_port: got we %b addr %0d data %0h expected 0 0 0", bus.bram_we, bus.bram_addr, bus.bram_data_in); end
    checks++; if (x_count !== 16'd0 || y_count !== 16'd0 || err_overflow !== 1'b0 || err_short !== 1'b0) begin errors++; $display("[TB] FAIL arst_state: got x %0d y %0d ovf %b short %b expected 0", x_count, y_count, err_overflow, err_short); end
`ifdef DOUBLE_BUFFER_EN
    checks++; if (disp_bank !== 1'b1) begin errors++; $display("[TB] FAIL arst_bank: got %b expected 1", disp_bank); end
`endif
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Run every scenario in order, then report
  initial begin
    rst_n = 1'b0;
    test_reset();
    test_first_line();
    test_full_frame();
    test_overflow();
    test_no_sof();
    test_short();
    test_sof_line_end();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
